// File: rtl/store_pkg.sv
// Shared definitions for the store alignment buffer: store mode encodings
// and small width helpers used by the formatter and the queue.
package store_pkg;

  localparam logic [2:0] ST_SB  = 3'b000;
  localparam logic [2:0] ST_SH  = 3'b001;
  localparam logic [2:0] ST_SW  = 3'b010;
  localparam logic [2:0] ST_SWL = 3'b011;
  localparam logic [2:0] ST_SWR = 3'b100;

  // Number of byte-offset bits inside one bus line.
  function automatic int ofsWidth(input int dataW);
    return $clog2(dataW / 8);
  endfunction

  // Number of line-tag bits for a byte address of width addrW.
  function automatic int tagWidth(input int addrW, input int dataW);
    return addrW - ofsWidth(dataW);
  endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store formatter: turns a GPR value plus mode and low address
// bits into lane-placed write data and byte strobes for a DATA_W-wide bus.
// Unstrobed bytes are driven to zero.
module store_lane_fmt
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                     mode,
  input  logic [$clog2(DATA_W/8)-1:0]    addrOfs,
  input  logic [31:0]                    data,
  output logic [DATA_W/8-1:0]            strb,
  output logic [DATA_W-1:0]              wdata,
  output logic                           illegal
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = ofsWidth(DATA_W);

  logic [1:0]        k_s;
  logic [OFS_W-1:0]  slot_s;
  logic [3:0]        wordStrb_s;
  logic [31:0]       wordData_s;
  logic [BYTES-1:0]  wideStrb_s;
  logic [DATA_W-1:0] wideData_s;

  assign k_s    = addrOfs[1:0];
  // Word slot within the line; collapses to zero on a 32-bit bus.
  assign slot_s = addrOfs >> 2;

  // Build the strobe/data pattern for one 32-bit word according to the mode.
  always_comb begin
    wordStrb_s = 4'b0000;
    wordData_s = 32'h0000_0000;
    illegal    = 1'b0;
    case (mode)
      ST_SB: begin
        wordStrb_s = 4'b0001 << k_s;
        wordData_s = {24'h00_0000, data[7:0]} << {k_s, 3'b000};
      end
      ST_SH: begin
        wordStrb_s = 4'b0011 << {k_s[1], 1'b0};
        wordData_s = {16'h0000, data[15:0]} << {k_s[1], 4'b0000};
      end
      ST_SW: begin
        wordStrb_s = 4'b1111;
        wordData_s = data;
      end
      ST_SWL: begin
        // Most significant k+1 bytes of the register land in lanes 0..k.
        wordStrb_s = 4'b1111 >> (2'd3 - k_s);
        wordData_s = data >> {2'd3 - k_s, 3'b000};
      end
      ST_SWR: begin
        // Least significant 4-k bytes of the register land in lanes k..3.
        wordStrb_s = 4'b1111 << k_s;
        wordData_s = data << {k_s, 3'b000};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Move the word pattern into its slot on the full bus.
  always_comb begin
    wideStrb_s       = '0;
    wideStrb_s[3:0]  = wordStrb_s;
    wideData_s       = '0;
    wideData_s[31:0] = wordData_s;
    strb             = wideStrb_s << {slot_s, 2'b00};
    wdata            = wideData_s << {slot_s, 5'b00000};
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store path between MEM and the data-memory write port: formats stores,
// queues them (optionally merging same-line stores into the tail entry),
// drains them under an addr_ok/data_ok handshake with a bounded number of
// outstanding writes, and reports when a load's line is still pending.
module store_align_buffer
  import store_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2,
  parameter bit MERGE_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_mode,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [31:0]         in_data,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_hit,
  output logic                idle,
  output logic                err_illegal
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFS_W  = ofsWidth(DATA_W);
  localparam int TAG_W  = tagWidth(ADDR_W, DATA_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int RING_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // Queue storage
  logic [TAG_W-1:0]  qTag_r  [DEPTH];
  logic [BYTES-1:0]  qStrb_r [DEPTH];
  logic [DATA_W-1:0] qData_r [DEPTH];
  logic [PTR_W-1:0]  headPtr_r;
  logic [PTR_W-1:0]  tailPtr_r;
  logic [PTR_W-1:0]  lastPtr_s;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  slotOfs_s [DEPTH];
  logic [DEPTH-1:0]  qValid_s;

  // Outstanding writes and the lines they target
  logic [OUT_W-1:0]     outst_r;
  logic [TAG_W-1:0]     flTag_r [MAX_OUTST];
  logic [MAX_OUTST-1:0] flValid_r;
  logic [RING_W-1:0]    flWr_r;
  logic [RING_W-1:0]    flRd_r;

  logic              errIllegal_r;
  logic [BYTES-1:0]  fmtStrb_s;
  logic [DATA_W-1:0] fmtData_s;
  logic              fmtIllegal_s;
  logic [DATA_W-1:0] mergeData_s;
  logic [TAG_W-1:0]  inTag_s;
  logic [TAG_W-1:0]  ldTag_s;
  logic              full_s;
  logic              empty_s;
  logic              mergeOk_s;
  logic              accept_s;
  logic              push_s;
  logic              merge_s;
  logic              pop_s;
  logic              retire_s;
  logic              hit_s;
  logic              unusedLdOfs_s;

  function automatic logic [RING_W-1:0] ringNext(input logic [RING_W-1:0] p);
    return (p == RING_W'(MAX_OUTST - 1)) ? RING_W'(0) : p + RING_W'(1);
  endfunction

  store_lane_fmt #(.DATA_W(DATA_W)) uFmt (
    .mode    (in_mode),
    .addrOfs (in_addr[OFS_W-1:0]),
    .data    (in_data),
    .strb    (fmtStrb_s),
    .wdata   (fmtData_s),
    .illegal (fmtIllegal_s)
  );

  assign inTag_s       = in_addr[ADDR_W-1:OFS_W];
  assign ldTag_s       = ld_addr[ADDR_W-1:OFS_W];
  assign unusedLdOfs_s = ^ld_addr[OFS_W-1:0];
  assign lastPtr_s     = tailPtr_r - PTR_W'(1);
  assign full_s        = (count_r == CNT_W'(DEPTH));
  assign empty_s       = (count_r == CNT_W'(0));
  // Requiring two entries keeps the head (which may be issuing) out of merges.
  assign mergeOk_s     = MERGE_EN && (count_r >= CNT_W'(2)) && (qTag_r[lastPtr_s] == inTag_s);
  assign in_ready      = !full_s || mergeOk_s;
  assign accept_s      = in_valid && in_ready;
  assign push_s        = accept_s && !fmtIllegal_s && !mergeOk_s;
  assign merge_s       = accept_s && !fmtIllegal_s && mergeOk_s;
  assign mem_req       = !empty_s && (outst_r < OUT_W'(MAX_OUTST));
  assign pop_s         = mem_req && mem_addr_ok;
  // A data_ok with nothing outstanding (e.g. left over from before a reset) is dropped.
  assign retire_s      = mem_data_ok && (outst_r != OUT_W'(0));
  assign mem_addr      = {qTag_r[headPtr_r], {OFS_W{1'b0}}};
  assign mem_wstrb     = qStrb_r[headPtr_r];
  assign mem_wdata     = qData_r[headPtr_r];
  assign ld_hit        = hit_s;
  assign idle          = empty_s && (outst_r == OUT_W'(0));
  assign err_illegal   = errIllegal_r;

  // Byte-wise overlay of the incoming store onto the tail entry.
  always_comb begin
    mergeData_s = qData_r[lastPtr_s];
    for (int b = 0; b < BYTES; b++) begin
      if (fmtStrb_s[b]) begin
        mergeData_s[8*b +: 8] = fmtData_s[8*b +: 8];
      end else begin
        mergeData_s[8*b +: 8] = qData_r[lastPtr_s][8*b +: 8];
      end
    end
  end

  // Mark which queue slots currently hold live entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slotOfs_s[i] = PTR_W'(i) - headPtr_r;
      qValid_s[i]  = ({1'b0, slotOfs_s[i]} < count_r);
    end
  end

  // Load hazard: any live queue entry or in-flight write on the load's line.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (qValid_s[i] && (qTag_r[i] == ldTag_s));
    end
    for (int j = 0; j < MAX_OUTST; j++) begin
      hit_s = hit_s | (flValid_r[j] && (flTag_r[j] == ldTag_s));
    end
  end

  // Queue entry storage: new entries at the tail, merges folded into the last entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        qTag_r[i]  <= '0;
        qStrb_r[i] <= '0;
        qData_r[i] <= '0;
      end
    end else if (push_s) begin
      qTag_r[tailPtr_r]  <= inTag_s;
      qStrb_r[tailPtr_r] <= fmtStrb_s;
      qData_r[tailPtr_r] <= fmtData_s;
    end else if (merge_s) begin
      qStrb_r[lastPtr_s] <= qStrb_r[lastPtr_s] | fmtStrb_s;
      qData_r[lastPtr_s] <= mergeData_s;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      headPtr_r <= PTR_W'(0);
      tailPtr_r <= PTR_W'(0);
      count_r   <= CNT_W'(0);
    end else begin
      if (pop_s) begin
        headPtr_r <= headPtr_r + PTR_W'(1);
      end
      if (push_s) begin
        tailPtr_r <= tailPtr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Outstanding-write counter: +1 per accepted issue, -1 per completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst_r <= OUT_W'(0);
    end else begin
      case ({pop_s, retire_s})
        2'b10:   outst_r <= outst_r + OUT_W'(1);
        2'b01:   outst_r <= outst_r - OUT_W'(1);
        default: outst_r <= outst_r;
      endcase
    end
  end

  // Ring of in-flight line tags; completions retire in issue order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < MAX_OUTST; j++) begin
        flTag_r[j] <= '0;
      end
      flValid_r <= '0;
      flWr_r    <= RING_W'(0);
      flRd_r    <= RING_W'(0);
    end else begin
      if (pop_s) begin
        flTag_r[flWr_r]   <= qTag_r[headPtr_r];
        flValid_r[flWr_r] <= 1'b1;
        flWr_r            <= ringNext(flWr_r);
      end
      if (retire_s) begin
        flValid_r[flRd_r] <= 1'b0;
        flRd_r            <= ringNext(flRd_r);
      end
    end
  end

  // One-cycle pulse when an illegal mode is accepted and dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      errIllegal_r <= 1'b0;
    end else begin
      errIllegal_r <= accept_s && fmtIllegal_s;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer on a 64-bit bus, 4-entry queue, 2 outstanding.
module tb_store_align_buffer;
  import store_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_mode = 3'b000;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_data = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic        ld_hit;
  logic        idle;
  logic        err_illegal;

  always #5 clk = ~clk;

  store_align_buffer #(
    .DATA_W(64), .ADDR_W(32), .DEPTH(4), .MAX_OUTST(2), .MERGE_EN(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_addr(in_addr), .in_data(in_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .idle(idle), .err_illegal(err_illegal)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] byteMask(input logic [7:0] s);
    logic [63:0] m;
    m = 64'h0;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
    exp_t e;
    e.addr  = a & 32'hFFFF_FFF8;
    e.strb  = s;
    e.wdata = d;
    sb.push_back(e);
  endtask

  // Offer one store for a single cycle; it is expected to be accepted.
  task automatic offer(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    check("offer in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((sb.size() != 0 || mem_req) && n < 40) begin
      tick();
      n++;
    end
    nChecks++;
    if (n >= 40) begin
      nErrors++;
      $display("FAIL %s: drain timeout, got %0d pending, expected 0", name, sb.size());
    end
  endtask

  // Scoreboard: every accepted write request is compared against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && mem_req && mem_addr_ok) begin
      if (sb.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL issue: got unexpected write to 0x%0h, expected none", mem_addr);
      end else begin
        e = sb.pop_front();
        check("issue addr", mem_addr, e.addr);
        check("issue strb", mem_wstrb, e.strb);
        check("issue data", mem_wdata & byteMask(mem_wstrb), e.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ST_SWL, 32'h0000_1001, 32'hAABB_CCDD, 8'h03, 64'h0000_0000_0000_AABB};
    vecs[1] = '{ST_SWR, 32'h0000_1002, 32'hAABB_CCDD, 8'h0C, 64'h0000_0000_CCDD_0000};
    vecs[2] = '{ST_SB,  32'h0000_3005, 32'h1234_5677, 8'h20, 64'h0000_7700_0000_0000};
    vecs[3] = '{ST_SH,  32'h0000_3002, 32'h0000_BEEF, 8'h0C, 64'h0000_0000_BEEF_0000};
    vecs[4] = '{ST_SW,  32'h0000_3004, 32'hDEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[5] = '{ST_SWL, 32'h0000_300F, 32'h1122_3344, 8'hF0, 64'h1122_3344_0000_0000};
    vecs[6] = '{ST_SWR, 32'h0000_3007, 32'h1122_3344, 8'h80, 64'h4400_0000_0000_0000};
    vecs[7] = '{ST_SWL, 32'h0000_3004, 32'h1122_3344, 8'h10, 64'h0000_0011_0000_0000};
    vecs[8] = '{ST_SB,  32'h0000_3000, 32'h0000_00FF, 8'h01, 64'h0000_0000_0000_00FF};

    // Reset state
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset mem_req", mem_req, 1'b0);
    check("reset idle", idle, 1'b1);
    check("reset ld_hit", ld_hit, 1'b0);
    check("reset err_illegal", err_illegal, 1'b0);
    tick();

    // Formatter vectors, each queued, issued and completed individually
    for (int i = 0; i < 9; i++) begin
      ld_addr = vecs[i].addr;
      offer(vecs[i].mode, vecs[i].addr, vecs[i].data);
      expectWrite(vecs[i].addr, vecs[i].strb, vecs[i].wdata);
      @(negedge clk);
      check("vec ld_hit queued", ld_hit, 1'b1);
      check("vec mem_req", mem_req, 1'b1);
      tick();
      mem_addr_ok = 1'b1;
      tick();
      mem_addr_ok = 1'b0;
      @(negedge clk);
      check("vec ld_hit in-flight", ld_hit, 1'b1);
      check("vec mem_req after issue", mem_req, 1'b0);
      check("vec idle in-flight", idle, 1'b0);
      tick();
      mem_data_ok = 1'b1;
      tick();
      mem_data_ok = 1'b0;
      @(negedge clk);
      check("vec ld_hit done", ld_hit, 1'b0);
      check("vec idle done", idle, 1'b1);
      tick();
    end
    check("vec scoreboard empty", sb.size(), 0);

    // Illegal modes are accepted, dropped and flagged for one cycle
    for (int m = 5; m < 8; m++) begin
      offer(3'(m), 32'h0000_4000, 32'h1111_2222);
      @(negedge clk);
      check("illegal err pulse", err_illegal, 1'b1);
      check("illegal not queued", mem_req, 1'b0);
      tick();
      @(negedge clk);
      check("illegal err cleared", err_illegal, 1'b0);
      check("illegal idle", idle, 1'b1);
      tick();
    end

    // Tail merge with three entries queued
    offer(ST_SW, 32'h0000_5000, 32'h0102_0304);
    expectWrite(32'h0000_5000, 8'h0F, 64'h0000_0000_0102_0304);
    offer(ST_SW, 32'h0000_500C, 32'h0506_0708);
    expectWrite(32'h0000_500C, 8'hF0, 64'h0506_0708_0000_0000);
    offer(ST_SH, 32'h0000_2006, 32'h0000_1234);
    offer(ST_SB, 32'h0000_2001, 32'h0000_0077);
    expectWrite(32'h0000_2000, 8'hC2, 64'h1234_0000_0000_7700);
    ld_addr = 32'h0000_2003;
    @(negedge clk);
    check("merge ld_hit line", ld_hit, 1'b1);
    tick();
    ld_addr = 32'h0000_6000;
    @(negedge clk);
    check("merge ld_hit miss", ld_hit, 1'b0);
    tick();
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    waitDrain("merge drain");
    mem_addr_ok = 1'b0;
    tick();
    mem_data_ok = 1'b0;
    tick();
    @(negedge clk);
    check("merge idle", idle, 1'b1);
    tick();

    // Fill to DEPTH with distinct lines, addr_ok held low
    for (int i = 0; i < 4; i++) begin
      offer(ST_SW, 32'h0000_6000 + 32'(8 * i), 32'hA000_0000 + 32'(i));
      expectWrite(32'h0000_6000 + 32'(8 * i), 8'h0F, 64'h0000_0000_A000_0000 + 64'(i));
    end
    in_valid = 1'b1;
    in_mode  = ST_SW;
    in_addr  = 32'h0000_6020;
    in_data  = 32'hA000_0004;
    @(negedge clk);
    check("full in_ready", in_ready, 1'b0);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check("full in_ready pre-pop", in_ready, 1'b0);
    tick();
    mem_addr_ok = 1'b0;
    @(negedge clk);
    check("in_ready after pop", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    expectWrite(32'h0000_6020, 8'h0F, 64'h0000_0000_A000_0004);

    // Outstanding limit: one in flight already, data_ok withheld
    mem_addr_ok = 1'b1;
    tick();
    @(negedge clk);
    check("outst cap mem_req", mem_req, 1'b0);
    tick();
    @(negedge clk);
    check("outst cap hold", mem_req, 1'b0);
    tick();
    mem_data_ok = 1'b1;
    tick();
    @(negedge clk);
    check("outst after data_ok", mem_req, 1'b1);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    check("outst same-cycle kept", mem_req, 1'b1);
    tick();
    @(negedge clk);
    check("outst cap again", mem_req, 1'b0);
    tick();
    mem_addr_ok = 1'b0;

    // Build 3 queued entries and 1 outstanding, then reset mid-transfer
    offer(ST_SW, 32'h0000_7000, 32'hB000_0000);
    offer(ST_SW, 32'h0000_7008, 32'hB000_0001);
    mem_data_ok = 1'b1;
    tick();
    mem_data_ok = 1'b0;
    ld_addr = 32'h0000_7000;
    @(negedge clk);
    check("pre-reset ld_hit", ld_hit, 1'b1);
    check("pre-reset idle", idle, 1'b0);
    tick();
    resetn = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid reset idle", idle, 1'b1);
    check("mid reset mem_req", mem_req, 1'b0);
    check("mid reset ld_hit", ld_hit, 1'b0);
    check("mid reset in_ready", in_ready, 1'b1);
    tick();
    resetn = 1'b1;
    mem_data_ok = 1'b1;
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    check("stray data_ok idle", idle, 1'b1);
    tick();
    ld_addr = 32'h0000_8000;
    offer(ST_SW, 32'h0000_8004, 32'hCAFE_F00D);
    expectWrite(32'h0000_8004, 8'hF0, 64'hCAFE_F00D_0000_0000);
    @(negedge clk);
    check("no underflow mem_req", mem_req, 1'b1);
    check("post-reset ld_hit", ld_hit, 1'b1);
    tick();
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    waitDrain("post-reset drain");
    mem_addr_ok = 1'b0;
    tick();
    mem_data_ok = 1'b0;
    tick();
    @(negedge clk);
    check("final idle", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
